// File: rtl/multi_cnt_disp_pkg.sv
// Shared constants and the 7-segment decode table for the multi-digit
// BCD counter with a multiplexed display.
package multi_cnt_disp_pkg;

  localparam int LOW_MOD = 60;
  localparam int TICK_W  = 32;

  typedef logic [6:0] seg_t;

  // Segment order is {a,b,c,d,e,f,g}, 1 = lit; non-decimal codes stay dark.
  function automatic seg_t seg_decode(input logic [3:0] dig);
    seg_t seg;
    case (dig)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/multi_cnt_disp_bcd_pair_cnt.sv
// One two-digit BCD counter stage, modulo MOD, with up/down stepping,
// validated load, and a same-cycle carry/borrow output.
module bcd_pair_cnt
  import multi_cnt_disp_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] cnt,
  output logic       co
);

  localparam logic [3:0] MAX_TENS = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MOD - 1) % 10);

  logic [3:0] tens;
  logic [3:0] ones;
  logic       at_max;
  logic       at_zero;

  assign tens    = cnt[7:4];
  assign ones    = cnt[3:0];
  assign at_max  = (cnt == {MAX_TENS, MAX_ONES});
  assign at_zero = (cnt == 8'h00);
  assign co      = en & (dir ? at_zero : at_max);

  // Malformed BCD or out-of-range values collapse to 00 rather than
  // leaving the counter in a state it could never reach by counting.
  function automatic logic [7:0] load_fix(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) ||
        ((int'(v[7:4]) * 10 + int'(v[3:0])) >= MOD))
      r = 8'h00;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'h00;
    end else if (load) begin
      cnt <= load_fix(load_val);
    end else if (en) begin
      if (!dir) begin
        if (at_max)
          cnt <= 8'h00;
        else if (ones == 4'd9)
          cnt <= {tens + 4'd1, 4'd0};
        else
          cnt <= {tens, ones + 4'd1};
      end else begin
        if (at_zero)
          cnt <= {MAX_TENS, MAX_ONES};
        else if (ones == 4'd0)
          cnt <= {tens - 4'd1, 4'd9};
        else
          cnt <= {tens, ones - 4'd1};
      end
    end
  end

endmodule

// File: rtl/multi_cnt_disp.sv
// Cascaded BCD pair counter (e.g. HH:MM:SS) driven by a programmable tick
// prescaler, with a time-multiplexed 7-segment display scan.
module multi_cnt_disp
  import multi_cnt_disp_pkg::*;
#(
  parameter int NUM_DIG  = 6,
  parameter int TOP_MOD  = 24,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            i_tick_num,
  input  logic                   i_run,
  input  logic                   i_dir,
  input  logic                   i_load,
  input  logic [4*NUM_DIG-1:0]   i_load_val,
  output logic [4*NUM_DIG-1:0]   o_bcd,
  output logic                   o_wrap,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic [NUM_DIG-1:0]     o_seg_enb
);

  localparam int NP    = NUM_DIG / 2;
  localparam int IDX_W = $clog2(NUM_DIG);
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [TICK_W-1:0] presc;
  logic [TICK_W-1:0] tick_lim;
  logic              tick;
  logic              tick_en;

  // A tick coincident with a load is dropped; the load owns that edge.
  assign tick_lim = (i_tick_num == 32'd0) ? '0 : (i_tick_num - 32'd1);
  assign tick     = i_run && (presc >= tick_lim);
  assign tick_en  = tick && !i_load;

  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (i_load || tick)
      presc <= '0;
    else if (i_run)
      presc <= presc + 32'd1;
  end

  logic [NP-1:0] en_chain;
  logic [NP-1:0] co;

  assign en_chain[0] = tick_en;

  for (genvar p = 0; p < NP; p++) begin : g_pair
    localparam int PMOD = (p == NP - 1) ? TOP_MOD : LOW_MOD;

    if (p > 0) begin : g_link
      assign en_chain[p] = co[p-1];
    end

    bcd_pair_cnt #(
      .MOD (PMOD)
    ) u_pair (
      .clk      (clk),
      .rst      (rst),
      .en       (en_chain[p]),
      .dir      (i_dir),
      .load     (i_load),
      .load_val (i_load_val[8*p +: 8]),
      .cnt      (o_bcd[8*p +: 8]),
      .co       (co[p])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      o_wrap <= 1'b0;
    else
      o_wrap <= co[NP-1];
  end

  logic [SC_W-1:0]  scan_cnt;
  logic [IDX_W-1:0] scan_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_W'(NUM_DIG - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0] digit_p0;

  always_comb begin
    digit_p0 = 4'd0;
    for (int k = 0; k < NUM_DIG; k++)
      if (scan_idx == IDX_W'(k))
        digit_p0 = o_bcd[4*k +: 4];
  end

  // p0 -> p1: display registers, one cycle behind scan index and count
  always_ff @(posedge clk) begin
    if (rst) begin
      o_seg     <= seg_decode(4'd0);
      o_seg_dp  <= 1'b0;
      o_seg_enb <= ~NUM_DIG'(1);
    end else begin
      o_seg     <= seg_decode(digit_p0);
      o_seg_dp  <= (int'(scan_idx) == 2) || (int'(scan_idx) == 4) ||
                   (int'(scan_idx) == 6);
      o_seg_enb <= ~(NUM_DIG'(1) << scan_idx);
    end
  end

endmodule

// File: doc/multi_cnt_disp.md
MULTI_CNT_DISP -- requirements
Module: multi_cnt_disp

Interface
REQ-001 SHALL have parameter NUM_DIG, default 6, giving the digit count (even, 2..8), arranged as NUM_DIG/2 two-digit BCD pairs; pair 0 is least significant.
REQ-002 SHALL have parameter TOP_MOD, default 24, giving the modulus of the top pair (2..100); all lower pairs are modulo 60.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles each digit is enabled during the display scan (>=1).
REQ-004 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 i_tick_num  input  32  clk cycles per count tick; 0 and 1 both mean every cycle.
REQ-007 i_run  input  1  1 = count; 0 = hold the count and the tick prescaler.
REQ-008 i_dir  input  1  0 = count up, 1 = count down.
REQ-009 i_load  input  1  one-cycle load strobe.
REQ-010 i_load_val  input  4*NUM_DIG  BCD load value, digit 0 in bits [3:0].
REQ-011 o_bcd  output  4*NUM_DIG  current count, BCD, registered.
REQ-012 o_wrap  output  1  one-cycle pulse when the top pair wraps.
REQ-013 o_seg  output  7  segments {a..g}, 1 = lit, registered.
REQ-014 o_seg_dp  output  1  decimal point, 1 = lit, registered.
REQ-015 o_seg_enb  output  NUM_DIG  digit enables, one-hot active-low, registered.

Function
REQ-016 SHALL derive tick from a 32-bit prescaler: if i_run=1 and prescaler >= i_tick_num-1 (saturated at 0), it clears and tick=1 for one cycle; otherwise, if i_run=1, it increments; if i_run=0, it holds. No derived clocks are allowed.
REQ-017 On tick with i_dir=0, pair 0 SHALL increment; a pair at mod-1 SHALL go to 00 and carry to the next pair in the same cycle.
REQ-018 On tick with i_dir=1, pair 0 SHALL decrement; a pair at 00 SHALL go to mod-1 and borrow from the next pair in the same cycle.
REQ-019 When the top pair wraps in either direction, o_wrap SHALL be 1 in the cycle the new o_bcd is visible, and 0 otherwise.
REQ-020 i_load SHALL take priority over tick: o_bcd becomes i_load_val on the next edge, the prescaler clears, the coincident tick is discarded, and o_wrap stays 0.
REQ-021 On load, any pair with a digit >9 or a value >= its modulus SHALL be stored as 00; valid pairs SHALL load unchanged.
REQ-022 The scan index SHALL advance 0..NUM_DIG-1 and wrap, stepping once every SCAN_DIV cycles; the scan is independent of i_run.
REQ-023 o_seg_enb bit k SHALL be 0 only while the scan index equals k; o_seg SHALL show the decoded digit k; o_seg_dp SHALL be 1 only for k = 2, 4, 6.
REQ-024 The decoder SHALL map 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, and >9 to 0000000.
REQ-025 The display outputs SHALL lag the scan index and the count by exactly one cycle.

Reset
REQ-026 When rst=1 at an edge, the next values SHALL be: prescaler 0, scan counter and index 0, o_bcd 0, o_wrap 0, o_seg 1111110, o_seg_dp 0, o_seg_enb all-ones except bit 0 = 0.
REQ-027 rst SHALL override i_load and tick in the same cycle, and SHALL act mid-count with no residual state.

Structure
REQ-028 A shared package SHALL hold the segment decode table, the lower-pair modulus constant 60, and the 32-bit tick-width constant.
REQ-029 A single sub-module, bcd_pair_cnt, SHALL implement one modulo-parametrised pair with enable, direction, load, carry/borrow out, and load validation, instantiated NUM_DIG/2 times.

Verification (NUM_DIG=6, TOP_MOD=24, SCAN_DIV=4 unless stated)
REQ-030 rst, then i_run=1, i_tick_num=3, i_dir=0 -> o_bcd increments every 3 cycles; after 60 ticks o_bcd=0x000100.
REQ-031 load 0x235959, up, one tick -> o_bcd=0x000000 and o_wrap high for exactly 1 cycle; load 0x000000, down, one tick -> 0x235959 with o_wrap.
REQ-032 i_load with tick in the same cycle, i_load_val=0x7A6512 -> o_bcd=0x000012, no increment, o_wrap=0.
REQ-033 load 0x123456, i_run=0 -> o_seg_enb steps 111110, 111101, ... each for 4 cycles; o_seg is 6, 5, 4, 3, 2, 1 patterns; o_seg_dp=1 only at indices 2 and 4; o_bcd holds.
REQ-034 rst pulsed for 1 cycle mid-count at 0x000537 -> next cycle all outputs match REQ-026; counting resumes from 0x000000.
REQ-035 i_tick_num=0 and 1 -> tick every cycle; toggling i_run=0 for 5 cycles -> count and prescaler frozen for those 5 cycles.
